// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: start/digit request and busy/done/result response bundle for bcd_to_bin
//   master: drives start, Hundreds, Tens, Ones; observes busy, done, binary, overflow, err
//   slave : the converter side of the same signals
interface bcd_to_bin_if;
    logic       start;
    logic [3:0] Hundreds;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic       busy;
    logic       done;
    logic [9:0] binary;
    logic       overflow;
    logic       err;
    modport master(output start, Hundreds, Tens, Ones, input busy, done, binary, overflow, err);
    modport slave(input start, Hundreds, Tens, Ones, output busy, done, binary, overflow, err);
endinterface

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble, 10 cycles)
//   clk, reset (sync, active-high)
//   b.start/Hundreds/Tens/Ones in; b.busy, b.done (1-cycle pulse), b.binary, b.overflow (> OUT_LIMIT), b.err out
//   BCD2BIN_DIGIT_CHECK_EN: when defined, digits > 9 finish one cycle after acceptance with err=1
module bcd_to_bin #(
    parameter int OUT_LIMIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    bcd_to_bin_if.slave     b
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state, state_n;
    logic [21:0] sr, sr_n, s, c;
    logic [3:0]  cnt, cnt_n;
    logic        busy, busy_n, done, done_n, ovf, ovf_n;
    logic [9:0]  bin, bin_n;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    logic        err, err_n, bad, bad_n;
`endif
    // one iteration: shift right, then pull each BCD nibble that reached >= 8 back by 3
    always_comb begin
        s = {1'b0, sr[21:1]};
        c = {s[21:18] >= 4'd8 ? s[21:18] - 4'd3 : s[21:18],
             s[17:14] >= 4'd8 ? s[17:14] - 4'd3 : s[17:14],
             s[13:10] >= 4'd8 ? s[13:10] - 4'd3 : s[13:10],
             s[9:0]};
    end
    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        bin_n   = bin;
        ovf_n   = ovf;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        err_n   = err;
        bad_n   = bad;
`endif
        if (state == IDLE) begin
            if (b.start) begin
                sr_n    = {b.Hundreds, b.Tens, b.Ones, 10'd0};
                cnt_n   = 4'd0;
                busy_n  = 1'b1;
                state_n = RUN;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                bad_n   = b.Hundreds > 4'd9 || b.Tens > 4'd9 || b.Ones > 4'd9;
`endif
            end
        end else begin
            sr_n  = c;
            cnt_n = cnt + 4'd1;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            if (bad) begin
                bin_n   = 10'd0;
                ovf_n   = 1'b0;
                err_n   = 1'b1;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end else
`endif
            if (cnt == 4'd9) begin
                bin_n   = c[9:0];
                ovf_n   = {22'd0, c[9:0]} > OUT_LIMIT;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
`ifdef BCD2BIN_DIGIT_CHECK_EN
                err_n   = 1'b0;
`endif
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            ovf   <= 1'b0;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err   <= 1'b0;
            bad   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            bin   <= bin_n;
            ovf   <= ovf_n;
`ifdef BCD2BIN_DIGIT_CHECK_EN
            err   <= err_n;
            bad   <= bad_n;
`endif
        end
    end
    assign b.busy     = busy;
    assign b.done     = done;
    assign b.binary   = bin;
    assign b.overflow = ovf;
`ifdef BCD2BIN_DIGIT_CHECK_EN
    assign b.err      = err;
`else
    assign b.err      = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: randomized scoreboard bench for bcd_to_bin against an arithmetic reference model
module tb_bcd_to_bin;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    logic prev_done = 1'b0;
    bcd_to_bin_if bi();
    bcd_to_bin dut (.clk(clk), .reset(reset), .b(bi));
    typedef struct {
        int bin;
        int ovf;
        int err;
        int acc;
        int lat;
    } exp_t;
    exp_t q[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    task automatic chk(string name, int act, int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    endtask
    // shift/subtract-3 steps on a plain integer, used only for non-BCD digits
    function automatic int dabble(int h, int t, int o);
        int v = (h << 18) + (t << 14) + (o << 10);
        for (int i = 0; i < 10; i++) begin
            v = v >> 1;
            for (int k = 0; k < 3; k++)
                if (((v >> (10 + 4 * k)) & 15) >= 8) v -= 3 << (10 + 4 * k);
        end
        return v & 1023;
    endfunction
    function automatic exp_t model(int h, int t, int o, int acc);
        exp_t e;
        bit bad = h > 9 || t > 9 || o > 9;
        e.acc = acc;
        e.err = 0;
        e.lat = 10;
        e.bin = bad ? dabble(h, t, o) : 100 * h + 10 * t + o;
`ifdef BCD2BIN_DIGIT_CHECK_EN
        if (bad) begin
            e.bin = 0;
            e.err = 1;
            e.lat = 1;
        end
`endif
        e.ovf = e.bin > 255 ? 1 : 0;
        return e;
    endfunction
    always @(negedge clk) begin
        if (bi.done) begin
            exp_t e;
            chk("done_pulse_width", int'(prev_done), 0);
            chk("done_expected", q.size() > 0 ? 1 : 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("binary", int'(bi.binary), e.bin);
                chk("overflow", int'(bi.overflow), e.ovf);
                chk("err", int'(bi.err), e.err);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
        prev_done = bi.done;
    end
    // called at a negedge; waits for idle, issues one start, optionally scrambles inputs while busy
    task automatic conv(int h, int t, int o, bit junk);
        int n = 0;
        while (bi.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("wait_idle", int'(bi.busy), 0);
        bi.Hundreds = 4'(h);
        bi.Tens = 4'(t);
        bi.Ones = 4'(o);
        bi.start = 1'b1;
        q.push_back(model(h, t, o, cyc + 1));
        @(negedge clk);
        bi.start = 1'b0;
        if (junk) begin
            n = 0;
            while (bi.busy && n < 50) begin
                bi.Hundreds = 4'($urandom_range(0, 15));
                bi.Tens = 4'($urandom_range(0, 15));
                bi.Ones = 4'($urandom_range(0, 15));
                bi.start = 1'($urandom);
                @(negedge clk);
                n++;
            end
            bi.start = 1'b0;
        end
    endtask
    task automatic chk_zero(string name);
        chk({name, "_busy"}, int'(bi.busy), 0);
        chk({name, "_done"}, int'(bi.done), 0);
        chk({name, "_binary"}, int'(bi.binary), 0);
        chk({name, "_overflow"}, int'(bi.overflow), 0);
        chk({name, "_err"}, int'(bi.err), 0);
    endtask
    initial begin
        int n;
        bi.start = 1'b0;
        bi.Hundreds = 4'd0;
        bi.Tens = 4'd0;
        bi.Ones = 4'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        conv(9, 9, 9, 0);
        n = 0;
        while (bi.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_cycles", n, 10);
        conv(2, 5, 5, 0);
        conv(2, 5, 6, 0);
        conv(0, 0, 0, 0);
        for (int i = 2; i <= 8; i++) begin
            bi.start = (i == 3 || i == 7) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        bi.start = 1'b0;
        repeat (6) @(negedge clk);
        conv(1, 2, 3, 0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk_zero("midrun_reset");
        repeat (14) @(negedge clk);
        chk("no_done_after_reset", int'(bi.done), 0);
        reset = 1'b1;
        bi.start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bi.start = 1'b0;
        chk("reset_beats_start", int'(bi.busy), 0);
        conv(1, 2, 3, 0);
        conv(0, 10, 1, 0);
        conv(0, 0, 0, 0);
        for (int v = 0; v < 1000; v++) conv(v / 100, (v / 10) % 10, v % 10, 1);
        for (int i = 0; i < 40; i++)
            conv($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), 1);
        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
